// File: rtl/tmds_pkg.sv
// Shared types and constants for the TMDS link sequencer: FSM state encoding,
// the four DVI control tokens and the counter width helper.
package tmds_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RESET     = 2'd1,
        TRAIN     = 2'd2,
        ACTIVE    = 2'd3
    } link_state_t;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // One spare bit so a counter can hold its terminal value and saturate there.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-stage synchronizer for an asynchronous level, with an optional
// stability debounce (DEBOUNCE_CYCLES = 0 bypasses it).
module sync_debounce #(
    parameter int STAGES          = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level
);

    logic [STAGES-1:0] r_sync;
    logic              w_sync;

    // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_async);
        end
    end

    assign w_sync = r_sync[STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign o_level = w_sync;
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

            logic [CW-1:0] r_cnt;
            logic          r_level;

            // The counter only runs while the synchronized input disagrees with
            // the debounced level, so any glitch shorter than the window is lost.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_sync == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= w_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_level = r_level;
        end
    endgenerate

endmodule

// File: rtl/tmds_link_sequencer.sv
// Brings the TMDS serializer from power-up to active video: qualify lock and
// hot-plug, hold serializer reset, send training tokens, switch to video on a frame.
module tmds_link_sequencer
    import tmds_pkg::*;
#(
    parameter int NUM_CHANNELS        = 3,
    parameter int SYNC_STAGES         = 2,
    parameter int RESET_CYCLES        = 16,
    parameter int TRAIN_CYCLES        = 1024,
    parameter int HPD_DEBOUNCE_CYCLES = 4096
) (
    input  logic                         clk_pixel,
    input  logic                         reset,
    input  logic                         pll_locked,
    input  logic                         hpd,
    input  logic                         retrain,
    input  logic                         frame_start,
    input  logic [NUM_CHANNELS-1:0][9:0] tmds_video,
    output logic [NUM_CHANNELS-1:0][9:0] tmds_out,
    output logic                         serializer_reset,
    output logic                         link_up,
    output logic [1:0]                   link_state
);

    localparam int CNT_W = cnt_width(RESET_CYCLES, TRAIN_CYCLES);

    logic             w_lock_s;
    logic             w_hpd_db;
    logic             w_link_ok;
    logic             w_reset_done;
    logic             w_train_done;
    logic             w_restart;
    link_state_t      w_next;
    link_state_t      r_state;
    logic [CNT_W-1:0] r_rst_cnt;
    logic [CNT_W-1:0] r_train_cnt;

    sync_debounce #(
        .STAGES          (SYNC_STAGES),
        .DEBOUNCE_CYCLES (0)
    ) u_lock_sync (
        .i_clk   (clk_pixel),
        .i_rst   (reset),
        .i_async (pll_locked),
        .o_level (w_lock_s)
    );

    sync_debounce #(
        .STAGES          (SYNC_STAGES),
        .DEBOUNCE_CYCLES (HPD_DEBOUNCE_CYCLES)
    ) u_hpd_sync (
        .i_clk   (clk_pixel),
        .i_rst   (reset),
        .i_async (hpd),
        .o_level (w_hpd_db)
    );

    assign w_link_ok    = w_lock_s && w_hpd_db;
    assign w_reset_done = (r_rst_cnt == CNT_W'(RESET_CYCLES - 1));
    assign w_train_done = (r_train_cnt == CNT_W'(TRAIN_CYCLES));

    // Loss of link_ok outranks retrain, which outranks normal progress.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            WAIT_LOCK: if (w_link_ok) w_next = RESET;
            RESET: begin
                if (!w_link_ok)                    w_next = WAIT_LOCK;
                else if (!retrain && w_reset_done) w_next = TRAIN;
            end
            TRAIN: begin
                if (!w_link_ok)                        w_next = WAIT_LOCK;
                else if (retrain)                      w_next = RESET;
                else if (frame_start && w_train_done)  w_next = ACTIVE;
            end
            ACTIVE: begin
                if (!w_link_ok)   w_next = WAIT_LOCK;
                else if (retrain) w_next = RESET;
            end
            default: w_next = WAIT_LOCK;
        endcase
    end

    // A retrain while already in RESET counts as a fresh entry.
    assign w_restart = (w_next != r_state) || ((r_state == RESET) && retrain);

    // Outputs decode the next state so they change on the same edge as link_state.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state          <= WAIT_LOCK;
            r_rst_cnt        <= '0;
            r_train_cnt      <= '0;
            serializer_reset <= 1'b1;
            link_up          <= 1'b0;
            tmds_out         <= {NUM_CHANNELS{TMDS_CTRL_00}};
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_rst_cnt   <= '0;
                r_train_cnt <= '0;
            end else begin
                if (r_state == RESET && r_rst_cnt != CNT_W'(RESET_CYCLES))
                    r_rst_cnt <= r_rst_cnt + 1'b1;
                if (r_state == TRAIN && r_train_cnt != CNT_W'(TRAIN_CYCLES))
                    r_train_cnt <= r_train_cnt + 1'b1;
            end
            serializer_reset <= (w_next == WAIT_LOCK) || (w_next == RESET);
            link_up          <= (w_next == ACTIVE);
            tmds_out         <= (w_next == ACTIVE) ? tmds_video : {NUM_CHANNELS{TMDS_CTRL_00}};
        end
    end

    assign link_state = r_state;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Self-checking bench for tmds_link_sequencer: randomized video and frame pulses
// compared every cycle against a cycle-level model of the link bring-up rules.
module tb_tmds_link_sequencer;

    localparam int NCH   = 3;
    localparam int VW    = NCH * 10;
    localparam int SYNC  = 2;
    localparam int RST_C = 4;
    localparam int TRN_C = 8;
    localparam int DB    = 16;
    localparam logic [9:0] TOKEN = 10'b1101010100;
    localparam int S_WAIT = 0, S_RESET = 1, S_TRAIN = 2, S_ACTIVE = 3;
    localparam logic [VW+3:0] RESET_VEC = {2'd0, 1'b1, 1'b0, {NCH{TOKEN}}};

    logic                clk_pixel = 1'b0;
    logic                reset = 1'b0;
    logic                pll_locked = 1'b0;
    logic                hpd = 1'b0;
    logic                retrain = 1'b0;
    logic                frame_start = 1'b0;
    logic [NCH-1:0][9:0] tmds_video = '0;
    logic [NCH-1:0][9:0] tmds_out;
    logic                serializer_reset;
    logic                link_up;
    logic [1:0]          link_state;

    int n_checks = 0;
    int n_fail   = 0;
    bit fixed_video = 1'b0;

    // Reference model: sync pipes, debounce run length, state and cycles spent in it.
    int                  m_lock_q [SYNC];
    int                  m_hpd_q  [SYNC];
    int                  m_hpd_db, m_hpd_run, m_state, m_age;
    logic [NCH-1:0][9:0] m_tmds;

    wire [VW+3:0] dut_vec = {link_state, serializer_reset, link_up, tmds_out};

    tmds_link_sequencer #(
        .NUM_CHANNELS        (NCH),
        .SYNC_STAGES         (SYNC),
        .RESET_CYCLES        (RST_C),
        .TRAIN_CYCLES        (TRN_C),
        .HPD_DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk_pixel        (clk_pixel),
        .reset            (reset),
        .pll_locked       (pll_locked),
        .hpd              (hpd),
        .retrain          (retrain),
        .frame_start      (frame_start),
        .tmds_video       (tmds_video),
        .tmds_out         (tmds_out),
        .serializer_reset (serializer_reset),
        .link_up          (link_up),
        .link_state       (link_state)
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [VW+3:0] exp_vec();
        logic ser = (m_state == S_WAIT) || (m_state == S_RESET);
        logic up  = (m_state == S_ACTIVE);
        return {2'(m_state), ser, up, m_tmds};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SYNC; i++) begin
            m_lock_q[i] = 0;
            m_hpd_q[i]  = 0;
        end
        m_hpd_db  = 0;
        m_hpd_run = 0;
        m_state   = S_WAIT;
        m_age     = 0;
        m_tmds    = {NCH{TOKEN}};
    endfunction

    function automatic void model_edge();
        int ok    = (m_lock_q[SYNC-1] != 0 && m_hpd_db != 0) ? 1 : 0;
        int hpd_s = m_hpd_q[SYNC-1];
        int nxt   = m_state;
        case (m_state)
            S_WAIT:  if (ok != 0) nxt = S_RESET;
            S_RESET: begin
                if (ok == 0)                              nxt = S_WAIT;
                else if (!retrain && m_age + 1 == RST_C)  nxt = S_TRAIN;
            end
            S_TRAIN: begin
                if (ok == 0)                              nxt = S_WAIT;
                else if (retrain)                         nxt = S_RESET;
                else if (frame_start && m_age >= TRN_C)   nxt = S_ACTIVE;
            end
            default: begin
                if (ok == 0)      nxt = S_WAIT;
                else if (retrain) nxt = S_RESET;
            end
        endcase
        if (nxt != m_state || (m_state == S_RESET && retrain)) m_age = 0;
        else                                                    m_age++;
        m_state = nxt;
        m_tmds  = (nxt == S_ACTIVE) ? tmds_video : {NCH{TOKEN}};
        // hpd_db flips once hpd_s has disagreed with it for DB consecutive cycles.
        if (hpd_s != m_hpd_db) m_hpd_run++;
        else                   m_hpd_run = 0;
        if (m_hpd_run == DB) begin
            m_hpd_db  = hpd_s;
            m_hpd_run = 0;
        end
        for (int i = SYNC - 1; i > 0; i--) begin
            m_lock_q[i] = m_lock_q[i-1];
            m_hpd_q[i]  = m_hpd_q[i-1];
        end
        m_lock_q[0] = int'(pll_locked);
        m_hpd_q[0]  = int'(hpd);
    endfunction

    task automatic step();
        @(posedge clk_pixel);
        if (reset) model_reset();
        else       model_edge();
        #1;
        retrain     = 1'b0;
        frame_start = 1'b0;
        tmds_video  = fixed_video ? {NCH{10'h2AA}} : VW'($urandom);
    endtask

    task automatic go_active(input string tag);
        int n = 0;
        while (link_state !== 2'(S_ACTIVE) && n < 300) begin
            frame_start = ($urandom_range(0, 7) == 0);
            step();
            n++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_seq: got %h want %h", tag, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (link_state !== 2'(S_ACTIVE)) begin
            n_fail++;
            $display("FAIL %s_reach_active: state %0d after %0d cycles, want 3", tag, link_state, n);
        end
    endtask

    task automatic wait_train(input string tag);
        int n = 0;
        while (link_state !== 2'(S_TRAIN) && n < 60) begin
            step();
            n++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL %s_to_train: got %h want %h", tag, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (link_state !== 2'(S_TRAIN)) begin
            n_fail++;
            $display("FAIL %s_reach_train: state %0d, want 2", tag, link_state);
        end
    endtask

    task automatic test_reset();
        model_reset();
        #1 reset = 1'b1;
        step();
        n_checks++;
        if (link_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d want 0", link_state);
        end
        n_checks++;
        if (serializer_reset !== 1'b1) begin
            n_fail++; $display("FAIL reset_ser: got %b want 1", serializer_reset);
        end
        n_checks++;
        if (link_up !== 1'b0) begin
            n_fail++; $display("FAIL reset_link_up: got %b want 0", link_up);
        end
        n_checks++;
        if (tmds_out !== {NCH{TOKEN}}) begin
            n_fail++; $display("FAIL reset_tmds: got %h want %h", tmds_out, {NCH{TOKEN}});
        end
    endtask

    task automatic test_bringup();
        int e_rst = -1, e_trn = -1, e_act = -1, fc;
        logic ser_at_trn = 1'bx, up_at_act = 1'bx;
        logic [VW-1:0] out_at_act = 'x;
        fixed_video = 1'b1;
        tmds_video  = {NCH{10'h2AA}};
        reset = 1'b0;
        hpd   = 1'b1;
        for (int c = 0; c < 200 && e_act < 0; c++) begin
            if (c == 20) pll_locked = 1'b1;
            frame_start = (c % 50 == 0);
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bringup_seq c=%0d: got %h want %h", c, dut_vec, exp_vec());
            end
            if (e_rst < 0 && link_state === 2'(S_RESET)) e_rst = c + 1;
            if (e_trn < 0 && link_state === 2'(S_TRAIN)) begin
                e_trn = c + 1;
                ser_at_trn = serializer_reset;
            end
            if (e_act < 0 && link_state === 2'(S_ACTIVE)) begin
                e_act = c + 1;
                out_at_act = tmds_out;
                up_at_act  = link_up;
            end
        end
        n_checks++;
        if (e_rst < 21 || e_rst - 20 > 3) begin
            n_fail++; $display("FAIL bringup_lock_to_reset: got %0d edges want <=3", e_rst - 20);
        end
        n_checks++;
        if (e_rst < 0 || e_trn - e_rst != RST_C) begin
            n_fail++; $display("FAIL bringup_reset_len: got %0d edges want %0d", e_trn - e_rst, RST_C);
        end
        n_checks++;
        if (ser_at_trn !== 1'b0) begin
            n_fail++; $display("FAIL bringup_ser_release: got %b want 0", ser_at_trn);
        end
        fc = ((e_trn + TRN_C + 49) / 50) * 50;
        n_checks++;
        if (e_act != fc + 1) begin
            n_fail++; $display("FAIL bringup_active_edge: got %0d want %0d", e_act, fc + 1);
        end
        n_checks++;
        if (out_at_act !== {NCH{10'h2AA}} || up_at_act !== 1'b1) begin
            n_fail++; $display("FAIL bringup_video: got %h/%b want %h/1", out_at_act, up_at_act, {NCH{10'h2AA}});
        end
        fixed_video = 1'b0;
    endtask

    task automatic test_hpd_glitch();
        int e = -1;
        logic ser_w = 1'bx, up_w = 1'bx;
        logic [VW-1:0] out_w = 'x;
        for (int i = 0; i < 40; i++) begin
            hpd = (i >= 10);
            step();
            n_checks++;
            if (link_state !== 2'(S_ACTIVE) || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL hpd_glitch_hold i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        hpd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) hpd = 1'b1;
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL hpd_drop_seq i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (e < 0 && link_state === 2'(S_WAIT)) begin
                e = i + 1;
                ser_w = serializer_reset;
                up_w  = link_up;
                out_w = tmds_out;
            end
        end
        n_checks++;
        if (e != DB + SYNC + 1) begin
            n_fail++; $display("FAIL hpd_drop_latency: got %0d edges want %0d", e, DB + SYNC + 1);
        end
        n_checks++;
        if (ser_w !== 1'b1 || up_w !== 1'b0 || out_w !== {NCH{TOKEN}}) begin
            n_fail++; $display("FAIL hpd_drop_outputs: got %b/%b/%h want 1/0/%h", ser_w, up_w, out_w, {NCH{TOKEN}});
        end
        go_active("hpd_recover");
    endtask

    task automatic test_lock_loss();
        int e = -1;
        for (int i = 0; i < 6; i++) begin
            pll_locked = (i != 0);
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL lock_loss_seq i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (e < 0 && link_state === 2'(S_WAIT)) e = i + 1;
        end
        n_checks++;
        if (e < 1 || e > SYNC + 1) begin
            n_fail++; $display("FAIL lock_loss_latency: got %0d edges want <=%0d", e, SYNC + 1);
        end
        go_active("lock_recover");
    endtask

    task automatic test_retrain();
        int k = 0;
        logic [VW-1:0] vid;
        retrain = 1'b1;
        step();
        n_checks++;
        if (link_state !== 2'(S_RESET) || serializer_reset !== 1'b1) begin
            n_fail++; $display("FAIL retrain_enter: got %0d/%b want 1/1", link_state, serializer_reset);
        end
        while (link_state !== 2'(S_TRAIN) && k < 10) begin
            step();
            k++;
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL retrain_reset_seq k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if (k != RST_C || serializer_reset !== 1'b0) begin
            n_fail++; $display("FAIL retrain_reset_len: got %0d/%b want %0d/0", k, serializer_reset, RST_C);
        end
        for (int i = 0; i < TRN_C; i++) begin
            step();
            n_checks++;
            if (link_state !== 2'(S_TRAIN) || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL retrain_train i=%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        vid = tmds_video;
        frame_start = 1'b1;
        step();
        n_checks++;
        if (link_state !== 2'(S_ACTIVE) || link_up !== 1'b1 || tmds_out !== vid) begin
            n_fail++; $display("FAIL retrain_video: got %0d/%b/%h want 3/1/%h", link_state, link_up, tmds_out, vid);
        end
    endtask

    task automatic test_early_frame();
        retrain = 1'b1;
        step();
        wait_train("early");
        for (int k = 0; k <= TRN_C; k++) begin
            frame_start = (k == 2 || k == TRN_C - 1 || k == TRN_C);
            step();
            n_checks++;
            if (link_state !== ((k >= TRN_C) ? 2'(S_ACTIVE) : 2'(S_TRAIN)) || dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL early_frame k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            pll_locked = (i != 0);
            retrain    = (i == 2);
            step();
        end
        n_checks++;
        if (link_state !== 2'(S_WAIT) || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL simul_lockloss_retrain: got %h want %h", dut_vec, exp_vec());
        end
        go_active("simul_a");
        retrain = 1'b1;
        step();
        wait_train("simul_b");
        for (int i = 0; i < TRN_C; i++) step();
        frame_start = 1'b1;
        retrain     = 1'b1;
        step();
        n_checks++;
        if (link_state !== 2'(S_RESET) || dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL simul_frame_retrain: got %h want %h", dut_vec, exp_vec());
        end
        go_active("simul_b");
    endtask

    task automatic test_async_reset();
        retrain = 1'b1;
        step();
        wait_train("areset");
        step();
        step();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL areset_train: got %h want %h", dut_vec, RESET_VEC);
        end
        model_reset();
        step();
        reset = 1'b0;
        go_active("areset_train");
        for (int i = 0; i < 3; i++) step();
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC) begin
            n_fail++; $display("FAIL areset_active: got %h want %h", dut_vec, RESET_VEC);
        end
        model_reset();
        step();
        reset = 1'b0;
        go_active("areset_active");
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_hpd_glitch();
        test_lock_loss();
        test_retrain();
        test_early_frame();
        test_simultaneous();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmds_link_sequencer.md
# tmds_link_sequencer

Pixel-clock-domain controller that sequences the TMDS serializer from power-up to active video. It waits for the x5 PLL to lock and for a debounced hot-plug detect, then holds the serializer in reset. It then drives a control-token training pattern and switches to encoded video only at a frame boundary. It sits between the TMDS channel encoders and the serializer, owning the serializer's reset and data inputs.

## Interface
Parameters:
- NUM_CHANNELS, default 3: number of TMDS data channels.
- SYNC_STAGES, default 2: flip-flop stages on each asynchronous input (pll_locked, hpd).
- RESET_CYCLES, default 16: clk_pixel cycles the serializer reset is held after lock and HPD are qualified.
- TRAIN_CYCLES, default 1024: minimum clk_pixel cycles of training tokens before video.
- HPD_DEBOUNCE_CYCLES, default 4096: cycles the synchronized hpd must be stable before its debounced value changes.

Ports:
- clk_pixel, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- pll_locked, in, 1: PLL lock, asynchronous to clk_pixel.
- hpd, in, 1: sink hot-plug detect, asynchronous.
- retrain, in, 1: single-cycle request to re-run the reset and training sequence.
- frame_start, in, 1: pulse coincident with the first pixel word of a frame on tmds_video.
- tmds_video, in, [NUM_CHANNELS-1:0][9:0]: encoded words from the channel encoders.
- tmds_out, out, [NUM_CHANNELS-1:0][9:0]: words to the serializer.
- serializer_reset, out, 1: serializer reset.
- link_up, out, 1: high while in ACTIVE.
- link_state, out, 2: current state encoding.

## Operation
- Synchronizers: lock_s and hpd_s are the outputs of SYNC_STAGES flip-flop chains, reset to 0.
- HPD debounce:
  - Counter clears whenever hpd_s equals hpd_db.
  - Otherwise the counter increments.
  - At HPD_DEBOUNCE_CYCLES-1, hpd_db takes hpd_s and the counter clears.
  - hpd_db resets to 0.
- Qualifier: link_ok = lock_s && hpd_db.
- State machine, link_state_t (WAIT_LOCK=0, RESET=1, TRAIN=2, ACTIVE=3). Priority: loss of link_ok > retrain > normal progress.
  - WAIT_LOCK: go to RESET when link_ok; retrain is ignored.
  - RESET: count cycles.
    - After RESET_CYCLES cycles in RESET, go to TRAIN.
    - If !link_ok, go to WAIT_LOCK.
    - retrain restarts the count.
  - TRAIN: count to TRAIN_CYCLES, then hold train_done.
    - Go to ACTIVE on the first frame_start with train_done; a frame_start arriving before train_done is ignored.
    - If !link_ok, go to WAIT_LOCK.
    - retrain goes to RESET.
  - ACTIVE: video pass-through.
    - If !link_ok, go to WAIT_LOCK.
    - retrain goes to RESET.
- Data mux:
  - tmds_out = tmds_video when the next state is ACTIVE.
  - Otherwise tmds_out = TMDS_CTRL_00 (10'b1101010100) on every channel.
- serializer_reset = 1 when the next state is WAIT_LOCK or RESET.
- link_up = 1 when the next state is ACTIVE.
- Counters:
  - Width is $clog2 of the largest count parameter plus 1; they saturate and never wrap.
  - Both counters clear on every state entry.

## Timing
- All outputs are registered and decoded from the next state, so they change on the same edge as link_state.
- Reset values:
  - link_state = WAIT_LOCK.
  - serializer_reset = 1.
  - link_up = 0.
  - tmds_out = TMDS_CTRL_00 on all channels.
  - Internal counters and hpd_db = 0.
- Async reset applies mid-sequence: all outputs immediately return to their reset values.
- Lock latency: pll_locked rising to lock_s high takes SYNC_STAGES to SYNC_STAGES+1 edges. With hpd_db already high, RESET is entered on the following edge.
- serializer_reset deasserts on the edge entering TRAIN, exactly RESET_CYCLES edges after RESET entry.
- Video latency is 1 cycle: the word presented with an accepted frame_start in cycle N appears on tmds_out after edge N, with link_up high.
- From ACTIVE, loss of lock is seen on tmds_out within SYNC_STAGES+1 edges: serializer_reset = 1, token on tmds_out, link_up = 0.
- Simultaneous events:
  - link_ok falling and retrain in the same cycle: go to WAIT_LOCK.
  - frame_start and retrain in TRAIN in the same cycle: go to RESET.

## Structure
- Package tmds_pkg holds:
  - link_state_t.
  - The four control tokens TMDS_CTRL_00/01/10/11.
  - A function returning max counter width.
- Sub-module sync_debounce: synchronizer plus optional debounce, with parameters STAGES and DEBOUNCE_CYCLES (0 = bypass).
  - Instantiated for hpd with HPD_DEBOUNCE_CYCLES.
  - Instantiated for pll_locked with DEBOUNCE_CYCLES = 0.
- The top-level holds only the FSM, the counters and the output registers.

## Test plan
Bench parameters: SYNC_STAGES=2, RESET_CYCLES=4, TRAIN_CYCLES=8, HPD_DEBOUNCE_CYCLES=16.
- Bring-up:
  - Stimulus: hpd high at t0, pll_locked high at t20, frame_start every 50 cycles, tmds_video = 10'h2AA.
  - Required: RESET entered ≤3 edges after lock.
  - Required: serializer_reset low after exactly 4 cycles in RESET.
  - Required: token 1101010100 until the first frame_start after ≥8 TRAIN cycles, then 10'h2AA one cycle after that frame_start with link_up = 1.
- HPD glitch:
  - Stimulus: from ACTIVE, hpd low for 10 cycles.
  - Required: state stays ACTIVE.
  - Stimulus: hpd low for 20 cycles.
  - Required: WAIT_LOCK entered 16+3 edges after the fall, serializer_reset = 1, token output.
- Lock loss: from ACTIVE, drop pll_locked for 1 cycle → WAIT_LOCK within 3 edges, then a full re-sequence.
- Retrain: pulse retrain in ACTIVE → RESET next edge, serializer_reset high for 4 cycles, 8 training cycles, ACTIVE at the next frame_start.
- Early frame: frame_start at TRAIN cycle 3 → ignored; ACTIVE only at the next frame_start after cycle 8.
- Async reset mid-sequence: assert reset during TRAIN and during ACTIVE → every output at its reset value before the next clock edge.
